// File: rtl/slight_step_ctrl.sv
// slight_step_ctrl: step-level controller for the SpoC-64 sLiSCP-light-192
// permutation. Holds the 192-bit state as four subblocks, drives two external
// SB round units with S1/S3, applies the step-constant mixing and subblock
// rotation for every step, and hands the permuted state to the mode controller.
module slight_step_ctrl #(
   parameter int WIDTH    = 48,
   parameter int NSTEPS   = 18,
   parameter int SBROUNDS = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [4*WIDTH-1:0]   state_in,
   input  logic [31:0]          step_const,
   output logic [4:0]           step_idx,
   output logic                 busy,
   output logic                 done,
   output logic [4*WIDTH-1:0]   state_out,
   output logic                 sb_en,
   output logic [WIDTH-1:0]     sb0_in,
   output logic [7:0]           sb0_rc,
   output logic [WIDTH-1:0]     sb1_in,
   output logic [7:0]           sb1_rc,
   input  logic [WIDTH-1:0]     sb0_out,
   input  logic [WIDTH-1:0]     sb1_out,
   input  logic                 sb_done
);

   // Index of the final step; step_idx parks here while the result is presented.
   localparam logic [4:0] LAST_STEP = 5'(NSTEPS - 1);

   // A zero-round SB unit, or a step count that step_idx cannot address, is a
   // configuration error; such a configuration elaborates no extra logic here.
   generate
      if (SBROUNDS < 1 || NSTEPS < 1 || NSTEPS > 32) begin : g_bad_config
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } fsm_t;

   fsm_t                fsm_q, fsm_d;
   logic [4*WIDTH-1:0]  state_q, state_d;
   logic [4:0]          step_q, step_d;

   // Subblock view of the state register: sub[0] = S0 (most significant).
   logic [WIDTH-1:0]    sub [4];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_sub
         assign sub[gi] = state_q[(3 - gi) * WIDTH +: WIDTH];
      end
   endgenerate

   // Step constants split out of the ROM word.
   logic [7:0]          rc0, rc1, sc0, sc1;
   assign rc0 = step_const[31:24];
   assign rc1 = step_const[23:16];
   assign sc0 = step_const[15:8];
   assign sc1 = step_const[7:0];

   // Step-constant masks: the upper WIDTH-8 bits are all ones, the low byte is sc.
   logic [WIDTH-1:0]    mask0, mask1;
   assign mask0 = {{(WIDTH - 8){1'b1}}, sc0};
   assign mask1 = {{(WIDTH - 8){1'b1}}, sc1};

   // Result of one step: mix the SB outputs into S0/S2, then rotate the
   // subblocks left by one so the next step feeds the mixed words to the SB units.
   logic [WIDTH-1:0]    t1, t3, n0, n2;
   logic [4*WIDTH-1:0]  stepped;
   assign t1      = sb0_out;
   assign t3      = sb1_out;
   assign n0      = sub[0] ^ t1 ^ mask0;
   assign n2      = sub[2] ^ t3 ^ mask1;
   assign stepped = {t1, n2, t3, n0};

   // State, step counter and FSM registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q   <= ST_IDLE;
         state_q <= '0;
         step_q  <= '0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         step_q  <= step_d;
      end
   end

   // Next-state logic: accept a start in IDLE, advance one step per SB
   // completion in RUN, present the result for one cycle in DONE.
   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      step_d  = step_q;
      case (fsm_q)
         ST_IDLE: begin
            if (start) begin
               state_d = state_in;
               step_d  = '0;
               fsm_d   = ST_RUN;
            end
         end
         ST_RUN: begin
            // The state only moves on the SB completion cycle, so SB inputs
            // and constants stay stable for the whole step.
            if (sb_done) begin
               state_d = stepped;
               if (step_q == LAST_STEP) begin
                  fsm_d = ST_DONE;
               end else begin
                  step_d = step_q + 5'd1;
               end
            end
         end
         ST_DONE: begin
            fsm_d = ST_IDLE;
         end
         default: begin
            fsm_d = ST_IDLE;
         end
      endcase
   end

   // Output decode from the registered state.
   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      sb_en     = 1'b0;
      step_idx  = step_q;
      state_out = state_q;
      sb0_in    = sub[1];
      sb1_in    = sub[3];
      sb0_rc    = rc0;
      sb1_rc    = rc1;
      case (fsm_q)
         ST_RUN: begin
            busy  = 1'b1;
            sb_en = 1'b1;
         end
         ST_DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_slight_step_ctrl.sv
// tb_slight_step_ctrl: scoreboard bench for slight_step_ctrl with behavioural
// SB round units and a combinational constant ROM.
`timescale 1ns/1ps
module tb_slight_step_ctrl;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [191:0]  state_in;
   logic [31:0]   step_const;
   logic [4:0]    step_idx;
   logic          busy;
   logic          done;
   logic [191:0]  state_out;
   logic          sb_en;
   logic [47:0]   sb0_in, sb1_in, sb0_out, sb1_out;
   logic [7:0]    sb0_rc, sb1_rc;
   logic          sb_done;

   int            total = 0;
   int            bad   = 0;
   int            perm_no = 0;

   // zero_mode: SB outputs forced to 0 and step constants forced to 0.
   logic          zero_mode = 1'b0;

   logic [191:0]  exp_q [$];
   logic [191:0]  exp_step0_q [$];

   always #5 clk = ~clk;

   slight_step_ctrl #(.WIDTH(48), .NSTEPS(18), .SBROUNDS(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .state_in   (state_in),
      .step_const (step_const),
      .step_idx   (step_idx),
      .busy       (busy),
      .done       (done),
      .state_out  (state_out),
      .sb_en      (sb_en),
      .sb0_in     (sb0_in),
      .sb0_rc     (sb0_rc),
      .sb1_in     (sb1_in),
      .sb1_rc     (sb1_rc),
      .sb0_out    (sb0_out),
      .sb1_out    (sb1_out),
      .sb_done    (sb_done)
   );

   // Stand-in SB round function (depends on both the input word and rc).
   function automatic logic [47:0] sb_func(input logic [47:0] x, input logic [7:0] rc);
      return {x[44:0], x[47:45]} ^ (x >> 5) ^ {40'd0, rc};
   endfunction

   function automatic logic [31:0] rom(input logic [4:0] i);
      logic [7:0] k;
      k = {3'd0, i};
      return {k * 8'd13 + 8'd7, k * 8'd29 + 8'd3, 8'hC3 ^ k, 8'h3C + k};
   endfunction

   assign step_const = zero_mode ? 32'd0 : rom(step_idx);

   // Behavioural SB pair: 6-round counter, samples inputs at count 0,
   // rnd_done on count 5, reset by the same rst net as the controller.
   logic [2:0]    sb_cnt;
   logic [47:0]   in0_r, in1_r;
   logic [7:0]    rc0_r, rc1_r;
   always @(posedge clk) begin
      if (rst) begin
         sb_cnt <= 3'd0;
         in0_r  <= 48'd0;
         in1_r  <= 48'd0;
         rc0_r  <= 8'd0;
         rc1_r  <= 8'd0;
      end else if (sb_en) begin
         if (sb_cnt == 3'd0) begin
            in0_r <= sb0_in;
            in1_r <= sb1_in;
            rc0_r <= sb0_rc;
            rc1_r <= sb1_rc;
         end
         sb_cnt <= (sb_cnt == 3'd5) ? 3'd0 : sb_cnt + 3'd1;
      end
   end
   assign sb_done = sb_en && (sb_cnt == 3'd5);
   assign sb0_out = zero_mode ? 48'd0 : sb_func(in0_r, rc0_r);
   assign sb1_out = zero_mode ? 48'd0 : sb_func(in1_r, rc1_r);

   // Reference permutation over 18 steps.
   function automatic logic [191:0] perm(input logic [191:0] s);
      logic [47:0] s0, s1, s2, s3, t1, t3, n0, n2;
      logic [31:0] c;
      {s0, s1, s2, s3} = s;
      for (int k = 0; k < 18; k++) begin
         c  = zero_mode ? 32'd0 : rom(5'(k));
         t1 = zero_mode ? 48'd0 : sb_func(s1, c[31:24]);
         t3 = zero_mode ? 48'd0 : sb_func(s3, c[23:16]);
         n0 = s0 ^ t1 ^ {40'hFF_FFFF_FFFF, c[15:8]};
         n2 = s2 ^ t3 ^ {40'hFF_FFFF_FFFF, c[7:0]};
         {s0, s1, s2, s3} = {t1, n2, t3, n0};
      end
      return {s0, s1, s2, s3};
   endfunction

   // ---------------- monitor ----------------
   logic          rst_at_edge = 1'b0;
   always @(posedge clk) rst_at_edge <= rst;

   int            busy_cnt   = 0;
   logic          prev_busy  = 1'b0;
   logic          prev_done  = 1'b0;
   logic [4:0]    prev_step  = 5'd0;
   logic [191:0]  prev_state = '0;
   logic [191:0]  exp_val;

   always @(negedge clk) begin
      if (rst_at_edge === 1'b1) begin
         total++;
         if (state_out !== 192'd0 || busy !== 1'b0 || done !== 1'b0 || sb_en !== 1'b0 || step_idx !== 5'd0) begin
            bad++;
            $display("FAIL reset_outputs: state_out=%h busy=%b done=%b sb_en=%b step_idx=%0d, required all zero",
                     state_out, busy, done, sb_en, step_idx);
         end else begin
            $display("reset: outputs zero");
         end
      end

      if (busy === 1'b1) begin
         busy_cnt++;
         total++;
         if (step_idx !== 5'((busy_cnt - 1) / 6)) begin
            bad++;
            $display("FAIL step_idx: run cycle %0d got %0d required %0d", busy_cnt, step_idx, (busy_cnt - 1) / 6);
         end
         total++;
         if (sb_en !== 1'b1 || sb0_in !== state_out[143:96] || sb1_in !== state_out[47:0]
             || sb0_rc !== step_const[31:24] || sb1_rc !== step_const[23:16]) begin
            bad++;
            $display("FAIL sb_drive: cycle %0d sb_en=%b sb0_in=%h sb1_in=%h rc=%h/%h, required en=1 S1=%h S3=%h rc=%h/%h",
                     busy_cnt, sb_en, sb0_in, sb1_in, sb0_rc, sb1_rc,
                     state_out[143:96], state_out[47:0], step_const[31:24], step_const[23:16]);
         end
         if (prev_busy && step_idx == prev_step) begin
            total++;
            if (state_out !== prev_state) begin
               bad++;
               $display("FAIL mid_step_change: cycle %0d state_out=%h required %h", busy_cnt, state_out, prev_state);
            end
         end
         if (prev_busy && prev_step == 5'd0 && step_idx == 5'd1 && exp_step0_q.size() > 0) begin
            exp_val = exp_step0_q.pop_front();
            total++;
            if (state_out !== exp_val) begin
               bad++;
               $display("FAIL step0_mix: state_out=%h required %h", state_out, exp_val);
            end else begin
               $display("step0 mix: state_out=%h", state_out);
            end
         end
      end else if (done === 1'b1) begin
         perm_no++;
         total++;
         if (busy_cnt != 108 || !prev_busy || sb_en !== 1'b0) begin
            bad++;
            $display("FAIL done_timing: busy cycles=%0d prev_busy=%b sb_en=%b, required 108/1/0",
                     busy_cnt, prev_busy, sb_en);
         end
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_done: state_out=%h with nothing expected", state_out);
         end else begin
            exp_val = exp_q.pop_front();
            if (state_out !== exp_val) begin
               bad++;
               $display("FAIL perm_result: perm %0d state_out=%h required %h", perm_no, state_out, exp_val);
            end else begin
               $display("perm %0d: state_out=%h", perm_no, state_out);
            end
         end
         busy_cnt = 0;
      end else begin
         busy_cnt = 0;
      end

      if (done === 1'b1 && prev_done === 1'b1) begin
         total++;
         bad++;
         $display("FAIL done_width: done high for consecutive cycles, required one cycle");
      end

      prev_busy  = (busy === 1'b1);
      prev_done  = done;
      prev_step  = step_idx;
      prev_state = state_out;
   end

   // ---------------- stimulus ----------------
   task automatic start_perm(input logic [191:0] s);
      @(posedge clk); #1;
      state_in = s;
      start    = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      state_in = ~s;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (done !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, n);
      end
   endtask

   localparam logic [191:0] PAT_A = {48'h0123_4567_89AB, 48'hCDEF_0123_4567, 48'h89AB_CDEF_0123, 48'h4567_89AB_CDEF};
   localparam logic [191:0] PAT_B = {48'hFFFF_0000_FFFF, 48'h0000_FFFF_0000, 48'hA5A5_A5A5_A5A5, 48'h5A5A_5A5A_5A5A};
   localparam logic [191:0] PAT_C = {48'hDEAD_BEEF_CAFE, 48'h1357_9BDF_0246, 48'h8000_0000_0001, 48'h7FFF_FFFF_FFFE};
   localparam logic [191:0] PAT_D = {48'h0000_0000_0001, 48'h0000_0000_0000, 48'hFFFF_FFFF_FFFF, 48'h1111_2222_3333};

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      state_in = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Full permutation of the all-zero state.
      zero_mode = 1'b0;
      exp_q.push_back(perm(192'd0));
      start_perm(192'd0);
      wait_done();

      // Mixing with zero SB outputs and zero constants.
      zero_mode = 1'b1;
      exp_step0_q.push_back({48'h0, 48'hFFFF_FFFF_FF03, 48'h0, 48'hFFFF_FFFF_FF01});
      exp_q.push_back(perm({48'h1, 48'h2, 48'h3, 48'h4}));
      start_perm({48'h1, 48'h2, 48'h3, 48'h4});
      wait_done();
      zero_mode = 1'b0;

      // Starts while busy must be ignored.
      exp_q.push_back(perm(PAT_A));
      start_perm(PAT_A);
      repeat (8) @(posedge clk);
      #1 start = 1'b1; state_in = PAT_B;
      @(posedge clk); #1 start = 1'b0;
      repeat (39) @(posedge clk);
      #1 start = 1'b1; state_in = PAT_C;
      @(posedge clk); #1 start = 1'b0;
      wait_done();

      // Reset in step 6 discards the run; a fresh start completes normally.
      start_perm(PAT_B);
      repeat (38) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      exp_q.push_back(perm(PAT_C));
      start_perm(PAT_C);
      wait_done();

      // Start in the first IDLE cycle after done is accepted.
      exp_q.push_back(perm(PAT_D));
      start_perm(PAT_D);
      wait_done();

      repeat (3) @(posedge clk);
      #1;
      total++;
      if (exp_q.size() != 0 || exp_step0_q.size() != 0) begin
         bad++;
         $display("FAIL leftover_expect: %0d results and %0d step checks outstanding, required 0",
                  exp_q.size(), exp_step0_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "simulation time limit reached");
   end

endmodule

// File: doc/slight_step_ctrl.md
Name: slight_step_ctrl

Overview:
- Step-level controller for the SpoC-64 sLiSCP-light-192 permutation.
- Holds the 192-bit state as four 48-bit subblocks S0..S3, with S0 in bits [191:144] and S3 in bits [47:0].
- Feeds S1 and S3 to two external SB round units, drives their enables and round constants, and consumes their outputs.
- Applies step-constant mixing and the subblock rotation for 18 steps, then presents the permuted state to the mode/datapath controller.

Parameters:
- WIDTH, 48, subblock width in bits; the state is 4*WIDTH.
- NSTEPS, 18, number of permutation steps.
- SBROUNDS, 6, rounds per SB invocation; must match the SB unit's counter wrap (0..5).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset; the same net drives both SB units
- start  input  1  one-cycle request to permute state_in; honoured only in IDLE
- state_in  input  4*WIDTH  state to permute, sampled on the accepted start cycle
- step_const  input  32  constants for step_idx, from the constant ROM: [31:24]=rc0, [23:16]=rc1, [15:8]=sc0, [7:0]=sc1
- step_idx  output  5  current step number, 0..NSTEPS-1; addresses the constant ROM combinationally
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when state_out holds the permuted result
- state_out  output  4*WIDTH  state register contents, {S0,S1,S2,S3}
- sb_en  output  1  en_rnd_ctr for both SB units
- sb0_in  output  WIDTH  S1, to SB unit 0
- sb0_rc  output  8  rc0
- sb1_in  output  WIDTH  S3, to SB unit 1
- sb1_rc  output  8  rc1
- sb0_out  input  WIDTH  SB unit 0 result (combinational from the SB unit)
- sb1_out  input  WIDTH  SB unit 1 result
- sb_done  input  1  SB unit 0 rnd_done; SB unit 1 is lock-stepped and its rnd_done is ignored

Behaviour:
- Reset values: state register = 0, step_idx = 0, FSM = IDLE, busy = 0, done = 0, sb_en = 0.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - start=1 loads state_in into the state register, clears step_idx to 0, and moves to RUN.
  - start=0 holds the state.
- RUN:
  - sb_en=1 on every cycle.
  - sb0_in=S1, sb1_in=S3, sb0_rc=step_const[31:24], sb1_rc=step_const[23:16], all held constant for the whole step.
  - The SB units sample their inputs when their internal counter is 0.
- On the RUN cycle where sb_done=1 (6th cycle of the step), the state updates to a new {S0,S1,S2,S3}:
  - T1 = sb0_out, T3 = sb1_out.
  - N0 = S0 ^ T1 ^ {(WIDTH-8) ones, sc0}.
  - N2 = S2 ^ T3 ^ {(WIDTH-8) ones, sc1}.
  - New state = {T1, N2, T3, N0} (left rotation by one subblock).
- On that same sb_done cycle:
  - If step_idx == NSTEPS-1, move to DONE and keep step_idx at NSTEPS-1.
  - Otherwise step_idx increments.
- The SB counters wrap to 0 on the same edge, so every step starts with the counters at 0. The controller does not otherwise track the SB counter.
- DONE: done=1 for exactly one cycle, sb_en=0, then return to IDLE. state_out holds the result until the next accepted start or reset.
- Latency: NSTEPS*SBROUNDS = 108 RUN cycles. The start edge is cycle 0, busy is high for cycles 1..108, and done is high in cycle 109.
- start while in RUN or DONE is ignored and must not disturb the state. start in the cycle after DONE (first IDLE cycle) is accepted.
- state_out changes only on start acceptance or at a step update; it never changes mid-step.
- sb0_out/sb1_out are don't-care outside the sb_done cycle.
- Reset mid-operation: all registers return to reset values on the next edge and any partial result is discarded. The SB units reset on the same edge, so their counters are consistent for the next start.
- step_const is combinational from step_idx and must be stable throughout a step. step_idx changes only at step boundaries.

Test Plan:
- Reset: assert rst 2 cycles -> state_out=0, busy=0, done=0, sb_en=0, step_idx=0.
- Full permutation, state_in=0, ROM with the spec constants, real SB units attached -> busy high exactly 108 cycles, done pulse at cycle 109, state_out equals the golden-model value for the zero input, step_idx sequence 0..17 with each value held 6 cycles.
- Mixing check with stub SB units (sb_out=0, sb_done every 6th cycle), step_const=0, state_in={48'h1,48'h2,48'h3,48'h4} -> after step 0, state_out={48'h0, 48'h3^48'hFFFFFFFFFF00, 48'h0, 48'h1^48'hFFFFFFFFFF00}.
- start pulsed at cycles 10 and 50 while busy, with a different state_in -> ignored; result is identical to the undisturbed run, done still at cycle 109.
- rst at cycle 40 (step 6) -> IDLE and all outputs zero next cycle; a fresh start then produces the correct result 108 cycles later.
- start asserted in the first IDLE cycle after done -> accepted, back-to-back permutation completes correctly.
